pc_next_controller: RTL and testbench

Fetch-stage next-address generator that sits directly upstream of the program counter register. Each cycle it computes the value the PC loads (sequential, branch redirect, reset vector or interrupt vector) and drives the PC hold control. It fetches 32-bit vectors as two 16-bit instruction-memory words. It also tells IF/ID whether the word at the current PC is a real instruction.

---
 rtl/pc_next_controller_if.sv | 33 +++
 rtl/pc_next_controller.sv | 131 +++++++++++++
 tb/tb_pc_next_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_next_controller_if.sv
// pc_next_controller_if: fetch-stage bundle between the next-address
// generator (master) and the surrounding PC register, instruction memory,
// hazard unit, execute stage and interrupt source (slave).
interface pc_next_controller_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 16
);
    logic                  stall;
    logic [ADDR_WIDTH-1:0] currentCount;
    logic [WORD_WIDTH-1:0] instrWord;
    logic                  hasImm;
    logic                  branchTaken;
    logic [ADDR_WIDTH-1:0] branchTarget;
    logic                  interrupt;
    logic [ADDR_WIDTH-1:0] nextCount;
    logic                  pcStall;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  fetchValid;
    logic                  intAck;
    logic [ADDR_WIDTH-1:0] intRetPc;

    modport master (
        input  stall, currentCount, instrWord, hasImm, branchTaken,
               branchTarget, interrupt,
        output nextCount, pcStall, memAddr, fetchValid, intAck, intRetPc
    );

    modport slave (
        output stall, currentCount, instrWord, hasImm, branchTaken,
               branchTarget, interrupt,
        input  nextCount, pcStall, memAddr, fetchValid, intAck, intRetPc
    );
endinterface

// File: rtl/pc_next_controller.sv
// pc_next_controller: computes the value the PC loads each cycle
// (sequential, branch redirect, reset vector, interrupt vector) and the PC
// hold control. Vectors are fetched as two instruction-memory words, high
// word first; the high half is parked in vec_hi for one cycle.
module pc_next_controller #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           WORD_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VEC_ADDR = '0,
    parameter logic [ADDR_WIDTH-1:0] INT_VEC_ADDR   = ADDR_WIDTH'(2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_next_controller_if.master bus
);

    typedef enum logic [2:0] {
        RST_HI,
        RST_LO,
        RUN,
        INT_HI,
        INT_LO
    } state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] vec_hi;
    logic                  pending;
    logic                  int_ack;
    logic [ADDR_WIDTH-1:0] int_ret_pc;

    logic [ADDR_WIDTH-1:0] seq_count;
    logic                  int_req;
    logic [ADDR_WIDTH-1:0] vec_word;

    // Sequential address, merged interrupt request and the assembled vector.
    always_comb begin
        seq_count = bus.currentCount + (bus.hasImm ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
        int_req   = pending | bus.interrupt;
        vec_word  = ADDR_WIDTH'({vec_hi, bus.instrWord});
    end

    // Combinational fetch outputs; branch beats stall beats interrupt in RUN.
    always_comb begin
        bus.nextCount  = bus.currentCount;
        bus.pcStall    = 1'b1;
        bus.memAddr    = RESET_VEC_ADDR;
        bus.fetchValid = 1'b0;
        case (state)
            RST_HI: begin
                bus.memAddr = RESET_VEC_ADDR;
            end
            RST_LO: begin
                bus.memAddr   = RESET_VEC_ADDR + ADDR_WIDTH'(1);
                bus.nextCount = vec_word;
                bus.pcStall   = 1'b0;
            end
            INT_HI: begin
                bus.memAddr = INT_VEC_ADDR;
            end
            INT_LO: begin
                bus.memAddr   = INT_VEC_ADDR + ADDR_WIDTH'(1);
                bus.nextCount = vec_word;
                bus.pcStall   = 1'b0;
            end
            RUN: begin
                bus.memAddr    = bus.currentCount;
                bus.fetchValid = 1'b1;
                if (bus.branchTaken) begin
                    bus.nextCount  = bus.branchTarget;
                    bus.pcStall    = 1'b0;
                    bus.fetchValid = 1'b0;
                end else if (bus.stall) begin
                    bus.pcStall = 1'b1;
                end else if (int_req) begin
                    bus.pcStall = 1'b1;
                end else begin
                    bus.nextCount = seq_count;
                    bus.pcStall   = 1'b0;
                end
            end
            default: begin
                bus.memAddr = RESET_VEC_ADDR;
            end
        endcase
    end

    // State sequencing, vector high-word capture, pending flag and interrupt acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_HI;
            vec_hi     <= '0;
            pending    <= 1'b0;
            int_ack    <= 1'b0;
            int_ret_pc <= '0;
        end else begin
            int_ack <= 1'b0;
            pending <= int_req;
            case (state)
                RST_HI: begin
                    vec_hi <= bus.instrWord;
                    state  <= RST_LO;
                end
                RST_LO: begin
                    state <= RUN;
                end
                INT_HI: begin
                    vec_hi <= bus.instrWord;
                    state  <= INT_LO;
                end
                INT_LO: begin
                    state <= RUN;
                end
                RUN: begin
                    if (!bus.branchTaken && !bus.stall && int_req) begin
                        int_ack    <= 1'b1;
                        int_ret_pc <= seq_count;
                        pending    <= 1'b0;
                        state      <= INT_HI;
                    end
                end
                default: begin
                    pending <= 1'b0;
                    state   <= RST_HI;
                end
            endcase
        end
    end

    assign bus.intAck   = int_ack;
    assign bus.intRetPc = int_ret_pc;

endmodule

// File: tb/tb_pc_next_controller.sv
// tb_pc_next_controller: directed bench for the fetch next-address
// generator. A small PC register model follows nextCount/pcStall when
// enabled; a four-word memory holds the reset and interrupt vectors.
module tb_pc_next_controller;

    logic clk;
    logic rst_n;
    logic follow;
    int   total;
    int   bad;

    pc_next_controller_if #(.ADDR_WIDTH(32), .WORD_WIDTH(16)) bus ();

    pc_next_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Vector memory: reset vector 0x00000100, interrupt vector 0x00000200.
    function automatic logic [15:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'd0:   return 16'h0000;
            32'd1:   return 16'h0100;
            32'd2:   return 16'h0000;
            32'd3:   return 16'h0200;
            default: return addr[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    assign bus.instrWord = mem_word(bus.memAddr);

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [31:0] cc;
        logic        imm;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] exp_next;
        logic        exp_stall;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [10];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic st, input logic imm, input logic br,
                                  input logic [31:0] tgt, input logic irq);
        bus.stall        = st;
        bus.hasImm       = imm;
        bus.branchTaken  = br;
        bus.branchTarget = tgt;
        bus.interrupt    = irq;
        #1;
    endtask

    // One clock: the PC model loads on the edge using pre-edge outputs.
    task automatic step();
        logic        st;
        logic [31:0] nc;
        st = bus.pcStall;
        nc = bus.nextCount;
        @(posedge clk);
        #1;
        if (follow && !st) bus.currentCount = nc;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        follow = 1'b1;
        rst_n = 1'b1;
        bus.currentCount = 32'hDEADBEEF;
        apply_stimulus(0, 0, 0, 32'h0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_output("rst_pcStall", 32'(bus.pcStall), 32'd1);
        check_output("rst_fetchValid", 32'(bus.fetchValid), 32'd0);
        check_output("rst_memAddr", bus.memAddr, 32'h0);
        check_output("rst_nextCount", bus.nextCount, 32'hDEADBEEF);
        check_output("rst_intAck", 32'(bus.intAck), 32'd0);
        check_output("rst_intRetPc", bus.intRetPc, 32'h0);

        // Boot: RST_HI, RST_LO, then first real fetch.
        rst_n = 1'b1;
        #1;
        check_output("boot1_pcStall", 32'(bus.pcStall), 32'd1);
        check_output("boot1_fetchValid", 32'(bus.fetchValid), 32'd0);
        step();
        check_output("boot2_pcStall", 32'(bus.pcStall), 32'd0);
        check_output("boot2_fetchValid", 32'(bus.fetchValid), 32'd0);
        check_output("boot2_memAddr", bus.memAddr, 32'h1);
        check_output("boot2_nextCount", bus.nextCount, 32'h100);
        step();
        check_output("boot3_memAddr", bus.memAddr, 32'h100);
        check_output("boot3_fetchValid", 32'(bus.fetchValid), 32'd1);
        check_output("boot3_nextCount", bus.nextCount, 32'h101);

        // Table-driven RUN vectors with the PC forced by the bench.
        vecs[0] = '{32'h00000010, 1'b0, 1'b0, 1'b0, 32'h0,    32'h00000011, 1'b0, 1'b1};
        vecs[1] = '{32'h00000010, 1'b1, 1'b0, 1'b0, 32'h0,    32'h00000012, 1'b0, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0,    32'h00000001, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0,    32'h00000000, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 32'h0,    32'h00000000, 1'b0, 1'b1};
        vecs[5] = '{32'h00000030, 1'b0, 1'b1, 1'b0, 32'h0,    32'h00000030, 1'b1, 1'b1};
        vecs[6] = '{32'h00000030, 1'b1, 1'b1, 1'b0, 32'h0,    32'h00000030, 1'b1, 1'b1};
        vecs[7] = '{32'h00000030, 1'b0, 1'b1, 1'b0, 32'h0,    32'h00000030, 1'b1, 1'b1};
        vecs[8] = '{32'h00000030, 1'b0, 1'b1, 1'b1, 32'h40,   32'h00000040, 1'b0, 1'b0};
        vecs[9] = '{32'h00000050, 1'b1, 1'b0, 1'b1, 32'h1234, 32'h00001234, 1'b0, 1'b0};
        follow = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.currentCount = vecs[i].cc;
            apply_stimulus(vecs[i].stall, vecs[i].imm, vecs[i].br, vecs[i].tgt, 1'b0);
            check_output($sformatf("vec%0d_nextCount", i), bus.nextCount, vecs[i].exp_next);
            check_output($sformatf("vec%0d_pcStall", i), 32'(bus.pcStall), 32'(vecs[i].exp_stall));
            check_output($sformatf("vec%0d_fetchValid", i), 32'(bus.fetchValid), 32'(vecs[i].exp_valid));
            check_output($sformatf("vec%0d_memAddr", i), bus.memAddr, vecs[i].cc);
            step();
        end

        // Interrupt accepted at 0x20 with a two-word instruction.
        bus.currentCount = 32'h20;
        follow = 1'b1;
        apply_stimulus(0, 1, 0, 32'h0, 1);
        check_output("acc_pcStall", 32'(bus.pcStall), 32'd1);
        check_output("acc_fetchValid", 32'(bus.fetchValid), 32'd1);
        check_output("acc_intAck", 32'(bus.intAck), 32'd0);
        step();
        apply_stimulus(0, 0, 0, 32'h0, 0);
        check_output("inthi_intAck", 32'(bus.intAck), 32'd1);
        check_output("inthi_intRetPc", bus.intRetPc, 32'h22);
        check_output("inthi_memAddr", bus.memAddr, 32'h2);
        check_output("inthi_pcStall", 32'(bus.pcStall), 32'd1);
        check_output("inthi_fetchValid", 32'(bus.fetchValid), 32'd0);
        step();
        check_output("intlo_intAck", 32'(bus.intAck), 32'd0);
        check_output("intlo_memAddr", bus.memAddr, 32'h3);
        check_output("intlo_nextCount", bus.nextCount, 32'h200);
        check_output("intlo_pcStall", 32'(bus.pcStall), 32'd0);
        step();
        check_output("isr_memAddr", bus.memAddr, 32'h200);
        check_output("isr_fetchValid", 32'(bus.fetchValid), 32'd1);
        check_output("isr_intRetPc", bus.intRetPc, 32'h22);
        check_output("isr_intAck", 32'(bus.intAck), 32'd0);

        // Interrupt coincident with a branch, then a merged second pulse during a stall.
        apply_stimulus(0, 0, 1, 32'h60, 1);
        check_output("brirq_nextCount", bus.nextCount, 32'h60);
        check_output("brirq_pcStall", 32'(bus.pcStall), 32'd0);
        check_output("brirq_fetchValid", 32'(bus.fetchValid), 32'd0);
        step();
        apply_stimulus(1, 0, 0, 32'h0, 1);
        check_output("stirq_pcStall", 32'(bus.pcStall), 32'd1);
        check_output("stirq_memAddr", bus.memAddr, 32'h60);
        step();
        apply_stimulus(0, 0, 0, 32'h0, 0);
        check_output("pend_acc_intAck", 32'(bus.intAck), 32'd0);
        check_output("pend_acc_pcStall", 32'(bus.pcStall), 32'd1);
        check_output("pend_acc_fetchValid", 32'(bus.fetchValid), 32'd1);
        step();
        check_output("pend_inthi_intAck", 32'(bus.intAck), 32'd1);
        check_output("pend_inthi_intRetPc", bus.intRetPc, 32'h61);
        step();
        check_output("pend_intlo_intAck", 32'(bus.intAck), 32'd0);
        step();
        check_output("merged_run_pcStall", 32'(bus.pcStall), 32'd0);
        check_output("merged_run_nextCount", bus.nextCount, 32'h201);
        step();
        check_output("merged_single_ack", 32'(bus.intAck), 32'd0);

        // Interrupt during RST_LO is accepted on the first RUN cycle.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        step();
        apply_stimulus(0, 0, 0, 32'h0, 1);
        check_output("rstlo_nextCount", bus.nextCount, 32'h100);
        step();
        apply_stimulus(0, 0, 0, 32'h0, 0);
        check_output("rstirq_acc_memAddr", bus.memAddr, 32'h100);
        check_output("rstirq_acc_pcStall", 32'(bus.pcStall), 32'd1);
        step();
        apply_stimulus(0, 0, 0, 32'h0, 1);
        check_output("rstirq_inthi_intAck", 32'(bus.intAck), 32'd1);
        check_output("rstirq_inthi_intRetPc", bus.intRetPc, 32'h101);
        step();
        apply_stimulus(0, 0, 0, 32'h0, 0);
        check_output("midvec_memAddr", bus.memAddr, 32'h3);

        // Reset during INT_LO with a pending request outstanding.
        rst_n = 1'b0;
        #1;
        check_output("midrst_pcStall", 32'(bus.pcStall), 32'd1);
        check_output("midrst_fetchValid", 32'(bus.fetchValid), 32'd0);
        check_output("midrst_memAddr", bus.memAddr, 32'h0);
        check_output("midrst_nextCount", bus.nextCount, bus.currentCount);
        check_output("midrst_intRetPc", bus.intRetPc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("reboot1_memAddr", bus.memAddr, 32'h0);
        step();
        check_output("reboot2_memAddr", bus.memAddr, 32'h1);
        check_output("reboot2_nextCount", bus.nextCount, 32'h100);
        step();
        check_output("reboot3_memAddr", bus.memAddr, 32'h100);
        check_output("reboot3_no_pending", 32'(bus.pcStall), 32'd0);
        check_output("reboot3_nextCount", bus.nextCount, 32'h101);
        step();
        check_output("reboot4_intAck", 32'(bus.intAck), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
